// File: rtl/led_bar_monitor_if.sv
// LED bar observation bus: the flasher-side master drives LED, the monitor slave reports
// decoded level, turns, run end and errors. Peak history signals exist only with PEAK_FIFO_EN.
interface led_bar_monitor_if #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 8,
    parameter int LVL_W = $clog2(WIDTH + 1)
);
    logic [WIDTH-1:0] LED;
    logic [LVL_W-1:0] level;
    logic [1:0]       mon_state;
    logic             peak_valid;
    logic             trough_valid;
    logic [LVL_W-1:0] turn_level;
    logic             seq_done;
    logic [CNT_W-1:0] seq_peaks;
    logic             err_format;
    logic             err_step;
    logic [CNT_W-1:0] err_cnt;
`ifdef PEAK_FIFO_EN
    logic             hist_rd;
    logic [LVL_W-1:0] hist_data;
    logic             hist_empty;
    logic             hist_ovf;
`endif

    modport master (
        output LED,
`ifdef PEAK_FIFO_EN
        output hist_rd,
        input  hist_data, hist_empty, hist_ovf,
`endif
        input  level, mon_state, peak_valid, trough_valid, turn_level,
               seq_done, seq_peaks, err_format, err_step, err_cnt
    );

    modport slave (
        input  LED,
`ifdef PEAK_FIFO_EN
        input  hist_rd,
        output hist_data, hist_empty, hist_ovf,
`endif
        output level, mon_state, peak_valid, trough_valid, turn_level,
               seq_done, seq_peaks, err_format, err_step, err_cnt
    );
endinterface

// File: rtl/led_bar_monitor.sv
// Passive thermometer-bar checker: registers LED, decodes level, tracks UP/DOWN runs,
// pulses on peaks/troughs/run end, flags bad bars and jumps. PEAK_FIFO_EN adds peak history.
module led_bar_monitor #(
    parameter int WIDTH       = 16,
    parameter int IDLE_CYCLES = 4,
    parameter int CNT_W       = 8
`ifdef PEAK_FIFO_EN
   ,parameter int FIFO_DEPTH  = 8
`endif
) (
    input  logic               clk,
    input  logic               reset,
    led_bar_monitor_if.slave   bus
);
    localparam int LVL_W = $clog2(WIDTH + 1);
    localparam int DW    = LVL_W + 1;
    localparam int IW    = $clog2(IDLE_CYCLES + 1);
    localparam logic [DW-1:0] D_ONE  = DW'(1);
    localparam logic [DW-1:0] D_MONE = {DW{1'b1}};

    typedef enum logic [1:0] {IDLE = 2'd0, UP = 2'd1, DOWN = 2'd2} state_t;

    logic [WIDTH-1:0] led_q;
    state_t           state_q, state_d;
    logic [LVL_W-1:0] level_q, level_d, turn_q, turn_d, n;
    logic [IW-1:0]    idle_q, idle_d;
    logic [CNT_W-1:0] run_pk_q, run_pk_d, seq_pk_q, seq_pk_d, err_q, err_d;
    logic             peak_q, peak_d, trough_q, trough_d, done_q, done_d;
    logic             fmt_q, fmt_d, step_q, step_d;
    logic             valid, pos, neg, big, err_inc;
    logic [DW-1:0]    delta;

    // A thermometer code plus one has no bits in common with itself (all-ones wraps to 0).
    assign valid = ((led_q & (led_q + WIDTH'(1))) == '0);

    always_comb begin
        n = '0;
        for (int i = 0; i < WIDTH; i++) n = n + LVL_W'(led_q[i]);
    end

    assign delta = {1'b0, n} - {1'b0, level_q};
    assign neg   = delta[DW-1];
    assign pos   = !delta[DW-1] && (delta != '0);
    assign big   = (pos && delta != D_ONE) || (neg && delta != D_MONE);

    always_comb begin
        state_d  = state_q;
        level_d  = level_q;
        turn_d   = turn_q;
        idle_d   = idle_q;
        run_pk_d = run_pk_q;
        seq_pk_d = seq_pk_q;
        err_d    = err_q;
        peak_d   = 1'b0;
        trough_d = 1'b0;
        done_d   = 1'b0;
        fmt_d    = 1'b0;
        step_d   = 1'b0;
        err_inc  = 1'b0;
        if (!valid) begin
            fmt_d   = 1'b1;
            err_inc = 1'b1;
        end else begin
            level_d = n;
            if (big) begin
                step_d  = 1'b1;
                err_inc = 1'b1;
            end
            if (n != '0) idle_d = '0;
            case (state_q)
                IDLE: if (pos) begin
                    state_d  = UP;
                    run_pk_d = '0;
                end
                UP: if (neg) begin
                    state_d = DOWN;
                    peak_d  = 1'b1;
                    turn_d  = level_q;
                    if (run_pk_q != '1) run_pk_d = run_pk_q + CNT_W'(1);
                end
                DOWN: begin
                    if (pos) begin
                        state_d  = UP;
                        trough_d = 1'b1;
                        turn_d   = level_q;
                    end else if (level_q == '0 && n == '0) begin
                        if (idle_q == IW'(IDLE_CYCLES - 1)) begin
                            state_d  = IDLE;
                            done_d   = 1'b1;
                            seq_pk_d = run_pk_q;
                            idle_d   = '0;
                        end else begin
                            idle_d = idle_q + IW'(1);
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        if (err_inc && err_q != '1) err_d = err_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            led_q    <= '0;
            state_q  <= IDLE;
            level_q  <= '0;
            turn_q   <= '0;
            idle_q   <= '0;
            run_pk_q <= '0;
            seq_pk_q <= '0;
            err_q    <= '0;
            peak_q   <= 1'b0;
            trough_q <= 1'b0;
            done_q   <= 1'b0;
            fmt_q    <= 1'b0;
            step_q   <= 1'b0;
        end else begin
            led_q    <= bus.LED;
            state_q  <= state_d;
            level_q  <= level_d;
            turn_q   <= turn_d;
            idle_q   <= idle_d;
            run_pk_q <= run_pk_d;
            seq_pk_q <= seq_pk_d;
            err_q    <= err_d;
            peak_q   <= peak_d;
            trough_q <= trough_d;
            done_q   <= done_d;
            fmt_q    <= fmt_d;
            step_q   <= step_d;
        end
    end

    assign bus.level        = level_q;
    assign bus.mon_state    = state_q;
    assign bus.peak_valid   = peak_q;
    assign bus.trough_valid = trough_q;
    assign bus.turn_level   = turn_q;
    assign bus.seq_done     = done_q;
    assign bus.seq_peaks    = seq_pk_q;
    assign bus.err_format   = fmt_q;
    assign bus.err_step     = step_q;
    assign bus.err_cnt      = err_q;

`ifdef PEAK_FIFO_EN
    localparam int PW = $clog2(FIFO_DEPTH);

    logic [LVL_W-1:0] mem_q [FIFO_DEPTH];
    logic [PW-1:0]    rd_q, wr_q;
    logic [PW:0]      cnt_q;
    logic             ovf_q, pop, push_ok;

    // Pushed alongside the peak pulse so the entry is readable when peak_valid is seen.
    assign pop     = bus.hist_rd && (cnt_q != '0);
    assign push_ok = peak_d && ((cnt_q != (PW+1)'(FIFO_DEPTH)) || pop);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            if (pop) rd_q <= rd_q + PW'(1);
            if (push_ok) wr_q <= wr_q + PW'(1);
            if (push_ok && !pop) cnt_q <= cnt_q + (PW+1)'(1);
            else if (pop && !push_ok) cnt_q <= cnt_q - (PW+1)'(1);
            if (peak_d && !push_ok) ovf_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_q] <= turn_d;
    end

    assign bus.hist_data  = mem_q[rd_q];
    assign bus.hist_empty = (cnt_q == '0);
    assign bus.hist_ovf   = ovf_q;
`endif
endmodule
